// File: rtl/timepulse_gen.sv
// timepulse_gen: turns the timer's CT / PHS2 / PHS4 phase levels into the one-hot
// T01..T12 time-pulse ring, a memory-cycle counter and a sticky phase-protocol error flag.
module timepulse_gen #(
    parameter int NPULSES = 12,
    parameter int MCT_W   = 16
) (
    input  logic               SIM_CLK,
    input  logic               SIM_RST,
    input  logic               PHS2,
    input  logic               PHS4,
    input  logic               CT,
    input  logic               GOJAM,
    input  logic               STOP,
    input  logic               ERR_CLR,
    output logic [NPULSES-1:0] T,
    output logic               P2_STB,
    output logic               P4_STB,
    output logic [MCT_W-1:0]   MCT,
    output logic               PHASE_ERR
);

    typedef enum logic [1:0] {
        WAIT_CT,
        EXP_P2,
        EXP_P4,
        EXP_CT
    } track_t;

    localparam logic [NPULSES-1:0] LP_T12 = {1'b1, {(NPULSES-1){1'b0}}};

    logic               r_ctQ;
    logic               r_p2Q;
    logic               r_p4Q;
    logic               r_armed;
    logic [NPULSES-1:0] r_t;
    logic [MCT_W-1:0]   r_mct;
    logic               r_live;
    logic               r_p2Stb;
    logic               r_p4Stb;
    logic               r_phaseErr;
    track_t             r_track;

    logic               w_ctRise;
    logic               w_p2Rise;
    logic               w_p4Rise;
    logic               w_multi;
    logic               w_atT12;
    logic               w_hold;
    logic               w_err;
    track_t             w_trackNext;

    // r_armed masks the first cycle after reset so a level already high at release
    // is not mistaken for a rising edge; it must toggle first.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_ctQ   <= 1'b0;
            r_p2Q   <= 1'b0;
            r_p4Q   <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_ctQ   <= CT;
            r_p2Q   <= PHS2;
            r_p4Q   <= PHS4;
            r_armed <= 1'b1;
        end
    end

    assign w_ctRise = r_armed & CT   & ~r_ctQ;
    assign w_p2Rise = r_armed & PHS2 & ~r_p2Q;
    assign w_p4Rise = r_armed & PHS4 & ~r_p4Q;
    assign w_multi  = (w_ctRise & w_p2Rise) | (w_ctRise & w_p4Rise) | (w_p2Rise & w_p4Rise);

    assign w_atT12  = r_t[NPULSES-1];
    assign w_hold   = STOP & w_atT12;

    // r_live marks a T12 reached by rotation; a T12 forced by reset or GOJAM is not
    // the end of a completed memory cycle, so leaving it does not bump MCT.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_t    <= LP_T12;
            r_mct  <= '0;
            r_live <= 1'b0;
        end else if (GOJAM) begin
            r_t    <= LP_T12;
            r_live <= 1'b0;
        end else if (w_ctRise && !w_hold) begin
            r_t    <= {r_t[NPULSES-2:0], r_t[NPULSES-1]};
            r_live <= 1'b1;
            if (w_atT12 && r_live) begin
                r_mct <= r_mct + MCT_W'(1);
            end
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_p2Stb <= 1'b0;
            r_p4Stb <= 1'b0;
        end else begin
            r_p2Stb <= w_p2Rise;
            r_p4Stb <= w_p4Rise;
        end
    end

    always_comb begin
        w_err       = w_multi;
        w_trackNext = r_track;
        case (r_track)
            WAIT_CT: begin
                if (w_ctRise) w_trackNext = EXP_P2;
            end
            EXP_P2: begin
                if (w_p2Rise) w_trackNext = EXP_P4;
                if (w_ctRise || w_p4Rise) w_err = 1'b1;
            end
            EXP_P4: begin
                if (w_p4Rise) w_trackNext = EXP_CT;
                if (w_ctRise || w_p2Rise) w_err = 1'b1;
            end
            EXP_CT: begin
                if (w_ctRise) w_trackNext = EXP_P2;
                if (w_p2Rise || w_p4Rise) w_err = 1'b1;
            end
            default: w_trackNext = WAIT_CT;
        endcase
        // Resync on the next CT so one glitch does not cascade into a string of errors.
        if (w_err) begin
            w_trackNext = w_ctRise ? EXP_P2 : EXP_CT;
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_track    <= WAIT_CT;
            r_phaseErr <= 1'b0;
        end else begin
            r_track <= w_trackNext;
            if (w_err) begin
                r_phaseErr <= 1'b1;
            end else if (ERR_CLR) begin
                r_phaseErr <= 1'b0;
            end
        end
    end

    assign T         = r_t;
    assign P2_STB    = r_p2Stb;
    assign P4_STB    = r_p4Stb;
    assign MCT       = r_mct;
    assign PHASE_ERR = r_phaseErr;

    a_tOneHot: assert property (@(posedge SIM_CLK) disable iff (!SIM_RST) $onehot(r_t));

endmodule

// File: tb/tb_timepulse_gen.sv
// tb_timepulse_gen: directed phase sequences for timepulse_gen; expected responses are
// queued by cycle number and checked by an independent monitor on the falling edge.
module tb_timepulse_gen;

    localparam int NP = 12;
    // Narrow counter so the wrap boundary is reachable in a short run.
    localparam int MW = 4;

    logic          SIM_CLK;
    logic          SIM_RST;
    logic          PHS2;
    logic          PHS4;
    logic          CT;
    logic          GOJAM;
    logic          STOP;
    logic          ERR_CLR;
    logic [NP-1:0] T;
    logic          P2_STB;
    logic          P4_STB;
    logic [MW-1:0] MCT;
    logic          PHASE_ERR;

    typedef struct {
        int            cyc;
        bit            isStb;
        logic [NP-1:0] t;
        logic [MW-1:0] mct;
        logic          err;
        logic          p2;
        logic          p4;
        int            tst;
    } exp_t;

    exp_t          sb[$];
    exp_t          cur;
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    int            testNo;
    int            expIdx;
    logic [MW-1:0] expMct;
    logic          expErr;
    bit            expLive;
    bit            stopLvl;

    timepulse_gen #(.NPULSES(NP), .MCT_W(MW)) dut (
        .SIM_CLK   (SIM_CLK),
        .SIM_RST   (SIM_RST),
        .PHS2      (PHS2),
        .PHS4      (PHS4),
        .CT        (CT),
        .GOJAM     (GOJAM),
        .STOP      (STOP),
        .ERR_CLR   (ERR_CLR),
        .T         (T),
        .P2_STB    (P2_STB),
        .P4_STB    (P4_STB),
        .MCT       (MCT),
        .PHASE_ERR (PHASE_ERR)
    );

    initial SIM_CLK = 1'b0;
    always #5 SIM_CLK = ~SIM_CLK;
    always @(posedge SIM_CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int tst,
                               input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL test%0d %s: got %0h expected %0h at cycle %0d",
                     tst, name, act, expv, cyc);
        end
    endtask

    always @(negedge SIM_CLK) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            if (cur.isStb) begin
                checkOutput("P2_STB", cur.tst, 32'(P2_STB), 32'(cur.p2));
                checkOutput("P4_STB", cur.tst, 32'(P4_STB), 32'(cur.p4));
            end else begin
                checkOutput("T", cur.tst, 32'(T), 32'(cur.t));
                checkOutput("MCT", cur.tst, 32'(MCT), 32'(cur.mct));
                checkOutput("PHASE_ERR", cur.tst, 32'(PHASE_ERR), 32'(cur.err));
            end
        end
    end

    task automatic tick();
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic ct, input logic p2, input logic p4,
                                 input logic gojam, input logic stop, input logic clr);
        CT      = ct;
        PHS2    = p2;
        PHS4    = p4;
        GOJAM   = gojam;
        STOP    = stop;
        ERR_CLR = clr;
    endtask

    task automatic pushState(input int c);
        exp_t n;
        n.cyc   = c;
        n.isStb = 1'b0;
        n.t     = {{(NP-1){1'b0}}, 1'b1} << expIdx;
        n.mct   = expMct;
        n.err   = expErr;
        n.p2    = 1'b0;
        n.p4    = 1'b0;
        n.tst   = testNo;
        sb.push_back(n);
    endtask

    task automatic pushStb(input int c, input logic p2, input logic p4);
        exp_t n;
        n.cyc   = c;
        n.isStb = 1'b1;
        n.t     = '0;
        n.mct   = '0;
        n.err   = 1'b0;
        n.p2    = p2;
        n.p4    = p4;
        n.tst   = testNo;
        sb.push_back(n);
    endtask

    // One CT rise as seen by the ring: hold at T12 under STOP, count only real cycles.
    task automatic advanceModel();
        if (stopLvl && expIdx == NP - 1) return;
        if (expIdx == NP - 1) begin
            if (expLive) expMct = expMct + 1'b1;
            expIdx = 0;
        end else begin
            expIdx = expIdx + 1;
        end
        expLive = 1'b1;
    endtask

    task automatic phasePeriod(input bit withP4, input bit errAtCt, input bit clrAtCt);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, stopLvl, clrAtCt);
        advanceModel();
        if (errAtCt) expErr = 1'b1;
        else if (clrAtCt) expErr = 1'b0;
        pushState(cyc + 1);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, stopLvl, 1'b0);
        pushStb(cyc + 1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, withP4, 1'b0, stopLvl, 1'b0);
        pushStb(cyc + 1, 1'b0, withP4);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, stopLvl, 1'b0);
        pushStb(cyc + 1, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        SIM_RST = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expIdx  = NP - 1;
        expMct  = '0;
        expErr  = 1'b0;
        expLive = 1'b0;
        stopLvl = 1'b0;
        testNo  = 0;
        tick();
        pushState(cyc);
        pushStb(cyc, 1'b0, 1'b0);
        tick();
        tick();
        SIM_RST = 1'b1;
        pushState(cyc + 1);
        tick();

        $display("[TB] test1: 13 well-formed periods");
        testNo = 1;
        repeat (13) phasePeriod(1'b1, 1'b0, 1'b0);

        $display("[TB] test2: missing PHS4, error and clear");
        testNo = 2;
        repeat (4) phasePeriod(1'b1, 1'b0, 1'b0);
        phasePeriod(1'b0, 1'b0, 1'b0);
        phasePeriod(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expErr = 1'b0;
        pushState(cyc + 1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) phasePeriod(1'b1, 1'b0, 1'b0);

        $display("[TB] test3: GOJAM at T07");
        testNo = 3;
        while (expIdx != 6) phasePeriod(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expIdx  = NP - 1;
        expLive = 1'b0;
        repeat (3) begin
            pushState(cyc + 1);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pushState(cyc + 1);
        tick();
        phasePeriod(1'b1, 1'b0, 1'b0);

        $display("[TB] test4: STOP from T10");
        testNo = 4;
        while (expIdx != 9) phasePeriod(1'b1, 1'b0, 1'b0);
        stopLvl = 1'b1;
        repeat (7) phasePeriod(1'b1, 1'b0, 1'b0);
        stopLvl = 1'b0;
        phasePeriod(1'b1, 1'b0, 1'b0);

        $display("[TB] test5: MCT wrap");
        testNo = 5;
        while (expMct != {MW{1'b1}} || expIdx != NP - 1) phasePeriod(1'b1, 1'b0, 1'b0);
        phasePeriod(1'b1, 1'b0, 1'b0);

        $display("[TB] test6: async reset at T06 with CT high");
        testNo = 6;
        while (expIdx != 5) phasePeriod(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        SIM_RST = 1'b0;
        expIdx  = NP - 1;
        expMct  = '0;
        expErr  = 1'b0;
        expLive = 1'b0;
        #1;
        pushState(cyc);
        pushStb(cyc, 1'b0, 1'b0);
        tick();
        pushState(cyc);
        tick();
        SIM_RST = 1'b1;
        repeat (4) begin
            pushState(cyc + 1);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pushState(cyc + 1);
        tick();
        phasePeriod(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
